// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared coin types, arbiter states and cent values for the coin front end
package vending_pkg;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_NICKLE,
        COIN_DIME,
        COIN_QUARTER
    } coin_e;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        GAP
    } cond_state_e;

    localparam logic [7:0] NICKLE_CENTS  = 8'd5;
    localparam logic [7:0] DIME_CENTS    = 8'd10;
    localparam logic [7:0] QUARTER_CENTS = 8'd25;

    function automatic logic [7:0] coin_cents(input coin_e coin);
        case (coin)
            COIN_NICKLE:  return NICKLE_CENTS;
            COIN_DIME:    return DIME_CENTS;
            COIN_QUARTER: return QUARTER_CENTS;
            default:      return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - per-line synchroniser, debouncer, rising-edge detect and jam detect
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic rise_o,
    output logic jam_o
);

    localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] JAM_LAST = 16'(JAM_CYCLES - 1);

    logic        sync_q1;
    logic        sync_q2;
    logic [7:0]  db_cnt_q;
    logic        level_q;
    logic        level_d1_q;
    logic        rise_q;
    logic [15:0] high_cnt_q;
    logic        jam_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            db_cnt_q   <= '0;
            level_q    <= 1'b0;
            level_d1_q <= 1'b0;
            rise_q     <= 1'b0;
            high_cnt_q <= '0;
            jam_q      <= 1'b0;
        end else begin
            sync_q1 <= raw_i;
            sync_q2 <= sync_q1;

            if (sync_q2 == level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_q  <= sync_q2;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 8'd1;
            end

            // Edge is registered one cycle after the level flips; a jammed line stays silent.
            level_d1_q <= level_q;
            rise_q     <= level_q & ~level_d1_q & ~jam_q;

            if (!level_q) begin
                high_cnt_q <= '0;
            end else if (high_cnt_q != JAM_LAST) begin
                high_cnt_q <= high_cnt_q + 16'd1;
            end

            if (level_q && (high_cnt_q == JAM_LAST)) begin
                jam_q <= 1'b1;
            end
        end
    end

    assign rise_o = rise_q;
    assign jam_o  = jam_q;

endmodule

// File: rtl/coin_conditioner.sv
// rtl/coin_conditioner.sv - coin front end: three debounced channels, 1-deep pending flags, serialising arbiter; COIN_TOTAL_EN adds a cent total
module coin_conditioner
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 1,
    parameter int JAM_CYCLES      = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       nickle_raw_i,
    input  logic       dime_raw_i,
    input  logic       quarter_raw_i,
`ifdef COIN_TOTAL_EN
    input  logic       clear_total_i,
    output logic [7:0] total_cents_o,
`endif
    output logic       nickle_o,
    output logic       dime_o,
    output logic       quarter_o,
    output logic       busy_o,
    output logic [2:0] jam_o
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

    logic [2:0]  raw;
    logic [2:0]  rise;
    logic [2:0]  pend_q;
    logic [2:0]  pend_d;
    logic [2:0]  grant;
    logic [3:0]  gap_q;
    logic [3:0]  gap_d;
    cond_state_e state_q;
    cond_state_e state_d;
    coin_e       sel;

    assign raw = {quarter_raw_i, dime_raw_i, nickle_raw_i};

    for (genvar i = 0; i < 3; i++) begin : g_ch
        coin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .JAM_CYCLES     (JAM_CYCLES)
        ) u_debounce (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .raw_i  (raw[i]),
            .rise_o (rise[i]),
            .jam_o  (jam_o[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gap_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        grant   = 3'b000;
        sel     = COIN_NONE;

        if (pend_q[2]) begin
            sel = COIN_QUARTER;
        end else if (pend_q[1]) begin
            sel = COIN_DIME;
        end else if (pend_q[0]) begin
            sel = COIN_NICKLE;
        end

        case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                grant   = {sel == COIN_QUARTER, sel == COIN_DIME, sel == COIN_NICKLE};
                gap_d   = GAP_LOAD;
                state_d = GAP;
            end
            GAP: begin
                gap_d = gap_q - 4'd1;
                // Chain straight into the next coin so the low gap is exactly GAP_CYCLES long.
                if (gap_q <= 4'd1) begin
                    state_d = (|pend_q) ? EMIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A set flag only clears on its own grant; an edge arriving while set is dropped.
        for (int i = 0; i < 3; i++) begin
            pend_d[i] = pend_q[i] ? ~grant[i] : rise[i];
        end
    end

    assign nickle_o  = grant[0];
    assign dime_o    = grant[1];
    assign quarter_o = grant[2];
    assign busy_o    = (state_q != IDLE) || (|pend_q);

`ifdef COIN_TOTAL_EN
    logic [7:0] total_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            total_q <= '0;
        end else if (clear_total_i) begin
            total_q <= '0;
        end else if (state_q == EMIT) begin
            total_q <= sat_add8(total_q, coin_cents(sel));
        end
    end

    assign total_cents_o = total_q;
`endif

endmodule
